// File: rtl/fifo_4k_sync_if.sv
// Handshake and status bundle for fifo_4k_sync.
// overflow/underflow exist only when FIFO_4K_SYNC_STATUS_EN is defined.
interface fifo_4k_sync_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
);
  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             rdempty;
  logic             wrfull;
  logic [AW-1:0]    rdusedw;
  logic [AW-1:0]    wrusedw;
`ifdef FIFO_4K_SYNC_STATUS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output data, wrreq, rdreq,
    input  q, rdempty, wrfull, rdusedw,
`ifdef FIFO_4K_SYNC_STATUS_EN
    input  overflow, underflow,
`endif
    input  wrusedw
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, rdempty, wrfull, rdusedw,
`ifdef FIFO_4K_SYNC_STATUS_EN
    output overflow, underflow,
`endif
    output wrusedw
  );
endinterface

// File: rtl/fifo_4k_sync.sv
// Single-clock 4095 x 16 show-ahead FIFO for the TX sample path.
// Define FIFO_4K_SYNC_STATUS_EN to add sticky overflow/underflow outputs.
module fifo_4k_sync #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input logic            clk,
  input logic            aclr_n,
  fifo_4k_sync_if.slave  bus
);

  localparam logic [AW-1:0] FULL_CNT = {AW{1'b1}};
  localparam int            DEPTH    = 1 << AW;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    count;
  logic             is_empty;
  logic             is_full;
  logic             wr_ok;
  logic             rd_ok;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  assign wr_ok    = bus.wrreq && !is_full;
  assign rd_ok    = bus.rdreq && !is_empty;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RAM has no reset; a write landing during reset is never exposed because
  // the count is held at zero and the slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data;
  end

  assign bus.q       = is_empty ? '0 : mem[rd_ptr];
  assign bus.rdempty = is_empty;
  assign bus.wrfull  = is_full;
  assign bus.rdusedw = count;
  assign bus.wrusedw = count;

`ifdef FIFO_4K_SYNC_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wrreq && is_full)  overflow_q  <= 1'b1;
      if (bus.rdreq && is_empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_4k_sync.sv
// Scoreboard bench for fifo_4k_sync; status checks compile in with FIFO_4K_SYNC_STATUS_EN.
module tb_fifo_4k_sync;

  localparam int WIDTH = 16;
  localparam int AW    = 12;
  localparam int CAP   = 4095;

  logic clk;
  logic aclr_n;

  fifo_4k_sync_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_4k_sync #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sb[$];
  int  m_count;
  bit  m_ovf;
  bit  m_unf;
  int  n_cmp;
  int  n_err;

  // Drives one cycle from a negedge; returns the scoreboard and DUT head word
  // for any pop the model accepts, so each scenario compares inline.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                      output bit popped, output logic [WIDTH-1:0] exp_q,
                      output logic [WIDTH-1:0] act_q);
    bit wr_ok, rd_ok;
    bus.wrreq = wr;
    bus.data  = d;
    bus.rdreq = rd;
    wr_ok  = wr && (m_count < CAP);
    rd_ok  = rd && (m_count > 0);
    popped = rd_ok;
    exp_q  = '0;
    act_q  = bus.q;
    if (wr && m_count == CAP) m_ovf = 1'b1;
    if (rd && m_count == 0)   m_unf = 1'b1;
    if (rd_ok) exp_q = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    m_count = m_count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
  endtask

  task automatic test_reset();
    aclr_n    = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;
    sb.delete();
    m_count = 0; m_ovf = 0; m_unf = 0;
    repeat (3) @(negedge clk);
    aclr_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0 || bus.wrusedw !== 12'd0 ||
        bus.rdusedw !== 12'd0 || bus.q !== 16'h0) begin
      n_err++;
      $display("FAIL reset_idle: got empty=%b full=%b wu=%0d ru=%0d q=%h, need 1 0 0 0 0000",
               bus.rdempty, bus.wrfull, bus.wrusedw, bus.rdusedw, bus.q);
    end
`ifdef FIFO_4K_SYNC_STATUS_EN
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: got ovf=%b unf=%b, need 0 0", bus.overflow, bus.underflow);
    end
`endif
  endtask

  task automatic test_two_words();
    bit p; logic [WIDTH-1:0] e, a;
    step(1'b1, 16'h1234, 1'b0, p, e, a);
    n_cmp++;
    if (bus.q !== 16'h1234 || bus.rdempty !== 1'b0) begin
      n_err++;
      $display("FAIL first_write: got q=%h empty=%b, need 1234 0", bus.q, bus.rdempty);
    end
    step(1'b1, 16'hABCD, 1'b0, p, e, a);
    n_cmp++;
    if (bus.wrusedw !== 12'd2 || bus.rdusedw !== 12'd2) begin
      n_err++;
      $display("FAIL usedw_two: got wu=%0d ru=%0d, need 2", bus.wrusedw, bus.rdusedw);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b1, p, e, a);
      if (p) begin
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL two_pop[%0d]: got q=%h, need %h", i, a, e);
        end
      end
      if (i == 0) begin
        n_cmp++;
        if (bus.q !== 16'hABCD) begin
          n_err++;
          $display("FAIL after_pop1: got q=%h, need abcd", bus.q);
        end
      end
    end
    n_cmp++;
    if (bus.rdempty !== 1'b1 || bus.q !== 16'h0) begin
      n_err++;
      $display("FAIL after_pop2: got empty=%b q=%h, need 1 0000", bus.rdempty, bus.q);
    end
  endtask

  task automatic test_fill_drain();
    bit p; logic [WIDTH-1:0] e, a;
    for (int i = 0; i < CAP; i++) step(1'b1, 16'(i), 1'b0, p, e, a);
    n_cmp++;
    if (bus.wrfull !== 1'b1 || bus.wrusedw !== 12'd4095 || bus.rdusedw !== 12'd4095) begin
      n_err++;
      $display("FAIL full: got full=%b wu=%0d ru=%0d, need 1 4095", bus.wrfull, bus.wrusedw, bus.rdusedw);
    end
    step(1'b1, 16'hFFFF, 1'b0, p, e, a);
    n_cmp++;
    if (bus.wrusedw !== 12'd4095 || bus.q !== 16'h0000) begin
      n_err++;
      $display("FAIL overfill: got wu=%0d q=%h, need 4095 0000", bus.wrusedw, bus.q);
    end
`ifdef FIFO_4K_SYNC_STATUS_EN
    n_cmp++;
    if (bus.overflow !== m_ovf) begin
      n_err++;
      $display("FAIL overflow: got %b, need %b", bus.overflow, m_ovf);
    end
`endif
    for (int i = 0; i < CAP; i++) begin
      step(1'b0, '0, 1'b1, p, e, a);
      if (p) begin
        n_cmp++;
        if (a !== e || a !== 16'(i)) begin
          n_err++;
          $display("FAIL drain[%0d]: got %h, need %h", i, a, 16'(i));
        end
      end
    end
    n_cmp++;
    if (bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0 || bus.rdusedw !== 12'd0) begin
      n_err++;
      $display("FAIL drained: got empty=%b full=%b ru=%0d, need 1 0 0", bus.rdempty, bus.wrfull, bus.rdusedw);
    end
  endtask

  task automatic test_back_to_back();
    bit p; logic [WIDTH-1:0] e, a;
    for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b0, p, e, a);
    for (int i = 0; i < 5000; i++) begin
      step(1'b1, 16'($urandom), 1'b1, p, e, a);
      if (p) begin
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h, need %h", i, a, e);
        end
      end
      if (i % 1000 == 999) begin
        n_cmp++;
        if (bus.wrusedw !== 12'd100 || 32'(bus.rdusedw) !== m_count) begin
          n_err++;
          $display("FAIL b2b_usedw[%0d]: got wu=%0d ru=%0d, need 100", i, bus.wrusedw, bus.rdusedw);
        end
      end
    end
    while (m_count > 0) begin
      step(1'b0, '0, 1'b1, p, e, a);
      if (p) begin
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL b2b_drain: got %h, need %h", a, e);
        end
      end
    end
  endtask

  task automatic test_empty_read();
    bit p; logic [WIDTH-1:0] e, a;
    step(1'b0, '0, 1'b1, p, e, a);
    n_cmp++;
    if (bus.rdusedw !== 12'd0 || bus.rdempty !== 1'b1 || bus.q !== 16'h0) begin
      n_err++;
      $display("FAIL empty_read: got ru=%0d empty=%b q=%h, need 0 1 0000", bus.rdusedw, bus.rdempty, bus.q);
    end
`ifdef FIFO_4K_SYNC_STATUS_EN
    n_cmp++;
    if (bus.underflow !== m_unf) begin
      n_err++;
      $display("FAIL underflow: got %b, need %b", bus.underflow, m_unf);
    end
`endif
    step(1'b1, 16'hBEEF, 1'b1, p, e, a);
    n_cmp++;
    if (bus.wrusedw !== 12'd1 || bus.q !== 16'hBEEF) begin
      n_err++;
      $display("FAIL empty_rw: got wu=%0d q=%h, need 1 beef", bus.wrusedw, bus.q);
    end
    step(1'b0, '0, 1'b1, p, e, a);
    if (p) begin
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL empty_rw_pop: got %h, need %h", a, e);
      end
    end
  endtask

  task automatic test_midstream_reset();
    bit p; logic [WIDTH-1:0] e, a;
    for (int i = 0; i < 37; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, p, e, a);
    n_cmp++;
    if (bus.wrusedw !== 12'd37) begin
      n_err++;
      $display("FAIL pre_reset_usedw: got %0d, need 37", bus.wrusedw);
    end
    bus.wrreq = 1'b1;
    bus.rdreq = 1'b1;
    bus.data  = 16'hDEAD;
    #2 aclr_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0 || bus.wrusedw !== 12'd0 ||
        bus.rdusedw !== 12'd0 || bus.q !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: got empty=%b full=%b wu=%0d ru=%0d q=%h, need 1 0 0 0 0000",
               bus.rdempty, bus.wrfull, bus.wrusedw, bus.rdusedw, bus.q);
    end
`ifdef FIFO_4K_SYNC_STATUS_EN
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_status: got ovf=%b unf=%b, need 0 0", bus.overflow, bus.underflow);
    end
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.wrusedw !== 12'd0 || bus.q !== 16'h0) begin
      n_err++;
      $display("FAIL held_reset: got wu=%0d q=%h, need 0 0000", bus.wrusedw, bus.q);
    end
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    aclr_n = 1'b1;
    sb.delete();
    m_count = 0; m_ovf = 0; m_unf = 0;
    step(1'b1, 16'h5A5A, 1'b0, p, e, a);
    n_cmp++;
    if (bus.q !== 16'h5A5A || bus.wrusedw !== 12'd1) begin
      n_err++;
      $display("FAIL post_reset_write: got q=%h wu=%0d, need 5a5a 1", bus.q, bus.wrusedw);
    end
    step(1'b0, '0, 1'b1, p, e, a);
    if (p) begin
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL post_reset_pop: got %h, need %h", a, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_two_words();
    test_fill_drain();
    test_back_to_back();
    test_empty_read();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_4k_sync.md
# fifo_4k_sync

Single-clock 4095 × 16 show-ahead FIFO, the synchronous counterpart of the TX sample FIFO used between the USB write path and the DAC-side loader. Writes push 16-bit words; the head word is always presented on `q` and `rdreq` pops it. Occupancy is reported on both "sides" for drop-in compatibility with existing level/space logic.

## Interface
Parameters:
- `WIDTH`, 16, data word width.
- `AW`, 12, address width; capacity is 2^AW − 1 = 4095 words.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: single clock for both read and write.
- `aclr_n` in 1: asynchronous reset, active-low.
- `data` in WIDTH: write word.
- `wrreq` in 1: push `data` on the rising `clk` edge.
- `rdreq` in 1: pop the head word on the rising `clk` edge.
- `q` out WIDTH: head word (show-ahead).
- `rdempty` out 1: FIFO holds 0 words.
- `wrfull` out 1: FIFO holds 4095 words.
- `rdusedw` out AW: words stored.
- `wrusedw` out AW: words stored, identical to `rdusedw`.

## Operation
- Storage: 2^AW × WIDTH RAM with AW-bit read and write pointers that wrap modulo 2^AW, plus an AW-bit registered count.
- Write: accepted when `wrreq`=1 and `wrfull`=0. The word is stored at `wr_ptr` and `wr_ptr` increments.
- Read: accepted when `rdreq`=1 and `rdempty`=0. `rd_ptr` increments, and `q` moves to the next word.
- Rejected requests (write while full, read while empty) are ignored; pointers, count and contents are unchanged.
- Count update per edge: +1 for an accepted write only; −1 for an accepted read only; unchanged when both or neither are accepted.
- Simultaneous read and write while empty: only the write is accepted, and the count becomes 1.
- Simultaneous read and write while full: only the read is accepted, and the count becomes 4094.
- Flags:
  - `rdempty` = (count == 0).
  - `wrfull` = (count == 4095).
  - `rdusedw` = `wrusedw` = count.
  - Because capacity is 4095, the count never overflows AW bits.
- `q` is forced to 0 while `rdempty`=1. Otherwise it equals the oldest stored word.
- Reset, asserted at any time including mid-operation:
  - pointers = 0, count = 0, `rdempty`=1, `wrfull`=0, `rdusedw`=`wrusedw`=0, `q`=0.
  - RAM contents are not cleared.
  - Any request active during reset is discarded.

## Timing
- All state updates on the rising edge of `clk`. `aclr_n` acts immediately and is released synchronously in effect (the first accepted operation is at the first edge with `aclr_n`=1).
- Write-to-read latency: a word written at edge N appears on `q`, with `rdempty`=0, after edge N; it can be popped at edge N+1.
- `q` is valid in the same cycle `rdreq` is sampled. The next word is presented after the pop edge.
- Flags and usedw are registered (derived from the count). They change only after an edge and never combinationally from `wrreq`/`rdreq`.

## Configuration
- `FIFO_4K_SYNC_STATUS_EN` defined: adds outputs `overflow` and `underflow`, each 1 bit and registered.
  - `overflow` is set on an edge with `wrreq`=1 and `wrfull`=1.
  - `underflow` is set on an edge with `rdreq`=1 and `rdempty`=1.
  - Both are sticky until `aclr_n`=0, and both reset to 0.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: `rdempty`=1, `wrfull`=0, `wrusedw`=0, `q`=0. Status flags are 0 when enabled.
- Write 0x1234 then 0xABCD, one per cycle, with no reads:
  - `q`=0x1234 and `rdempty`=0 after the first edge; usedw=2 after the second.
  - Pop with `rdreq`: `q`=0xABCD next; after the second pop, `rdempty`=1 and `q`=0.
- Fill with 4095 incrementing words:
  - `wrfull`=1 and usedw=4095.
  - A 4096th write is ignored (`overflow`=1 if enabled).
  - Drain all 4095 words: they come out in order 0…4094, and the pointers wrap correctly.
- Continuous simultaneous read and write at usedw=100 for 5000 cycles: usedw stays 100 and data order is preserved across pointer wrap.
- `rdreq` while empty: no state change, `q`=0 (`underflow`=1 if enabled). Simultaneous read and write while empty: usedw=1 and `q` equals the written word.
- Assert `aclr_n`=0 mid-stream at usedw=37: outputs immediately return to their reset values. After release, a new write is the first word seen on `q`.
